// File: rtl/winograd_f23_engine.sv
// winograd_f23_engine
// Winograd F(2,3) convolution engine. A 3-tap filter is loaded once and
// kept. Each accepted 4-sample tile d0..d3 then yields
//    y0 = d0*g0 + d1*g1 + d2*g2
//    y1 = d1*g0 + d2*g1 + d3*g2
// The four Winograd products are computed on NUM_MUL shared multipliers
// in 4/NUM_MUL passes.
//
// Ports
//    clk, rst_n            clock, asynchronous active-low reset
//    w_load / w_ready      filter load handshake; g0..g2 taps
//    in_valid / in_ready   tile handshake; d0..d3 samples
//    out_valid / out_ready result handshake; y0, y1 results
//    busy                  engine not idle
module winograd_f23_engine #(
   parameter int DATA_W  = 16,
   parameter int NUM_MUL = 1,
   parameter int OUT_W   = 2*DATA_W+2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     w_load,
   output logic                     w_ready,
   input  logic signed [DATA_W-1:0] g0,
   input  logic signed [DATA_W-1:0] g1,
   input  logic signed [DATA_W-1:0] g2,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] d0,
   input  logic signed [DATA_W-1:0] d1,
   input  logic signed [DATA_W-1:0] d2,
   input  logic signed [DATA_W-1:0] d3,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  y0,
   output logic signed [OUT_W-1:0]  y1,
   output logic                     busy
);

   localparam int MW = DATA_W + 1;     // tile transform width
   localparam int SW = DATA_W + 2;     // un-halved filter sum width
   localparam int PW = 2*DATA_W + 3;   // product width
   localparam int FW = PW + 1;         // final sum width
   localparam int P  = 4 / NUM_MUL;    // passes per tile

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_SUM, S_HOLD} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [1:0]              r_cnt;
   logic                    w_accept;
   logic                    w_wtake;

   logic signed [DATA_W-1:0] r_k0;
   logic signed [SW-1:0]     r_s1;
   logic signed [SW-1:0]     r_s2;
   logic signed [DATA_W-1:0] r_k3;

   logic signed [MW-1:0]     r_m_p0 [4];
   logic signed [PW-1:0]     r_t_p1 [4];
   logic signed [OUT_W-1:0]  r_y0_p2;
   logic signed [OUT_W-1:0]  r_y1_p2;

   logic [1:0]               w_idx  [NUM_MUL];
   logic signed [PW-1:0]     w_opa  [NUM_MUL];
   logic signed [PW-1:0]     w_opb  [NUM_MUL];
   logic signed [PW-1:0]     w_prod [NUM_MUL];

   logic signed [FW-1:0]     w_sum;
   logic signed [FW-1:0]     w_dif;
   logic signed [FW-1:0]     w_h;
   logic signed [FW-1:0]     w_g;
   logic signed [FW-1:0]     w_y0;
   logic signed [FW-1:0]     w_y1;

   // The full-width sums always fit in OUT_W, so narrowing drops only
   // redundant sign bits.
   function automatic logic signed [OUT_W-1:0] f_narrow(input logic signed [FW-1:0] v);
      return v[OUT_W-1:0];
   endfunction

   // A load has priority over a tile in the same IDLE cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      in_ready    = 1'b0;
      busy        = 1'b1;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready  = 1'b1;
            in_ready = ~w_load;
            busy     = 1'b0;
            if (in_valid && !w_load) w_state_nxt = S_MUL;
         end
         S_MUL:  if (r_cnt == 2'(P-1)) w_state_nxt = S_SUM;
         S_SUM:  w_state_nxt = S_HOLD;
         S_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_accept = in_valid & in_ready;
   assign w_wtake  = w_load & w_ready;
   assign y0       = r_y0_p2;
   assign y1       = r_y1_p2;

   // Pass r_cnt feeds products r_cnt*NUM_MUL .. r_cnt*NUM_MUL+NUM_MUL-1.
   always_comb begin
      for (int j = 0; j < NUM_MUL; j++) begin
         w_idx[j] = 2'(int'(r_cnt) * NUM_MUL + j);
         w_opa[j] = PW'(r_m_p0[w_idx[j]]);
         case (w_idx[j])
            2'd0:    w_opb[j] = PW'(r_k0);
            2'd1:    w_opb[j] = PW'(r_s1);
            2'd2:    w_opb[j] = PW'(r_s2);
            default: w_opb[j] = PW'(r_k3);
         endcase
         w_prod[j] = w_opa[j] * w_opb[j];
      end
   end

   // t1+t2 and t1-t2 are always even, so the arithmetic shift is exact.
   always_comb begin
      w_sum = FW'(r_t_p1[1]) + FW'(r_t_p1[2]);
      w_dif = FW'(r_t_p1[1]) - FW'(r_t_p1[2]);
      w_h   = w_sum >>> 1;
      w_g   = w_dif >>> 1;
      w_y0  = FW'(r_t_p1[0]) + w_h;
      w_y1  = w_g - FW'(r_t_p1[3]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 2'd0;
         r_k0    <= '0;
         r_s1    <= '0;
         r_s2    <= '0;
         r_k3    <= '0;
         r_y0_p2 <= '0;
         r_y1_p2 <= '0;
         for (int i = 0; i < 4; i++) begin
            r_m_p0[i] <= '0;
            r_t_p1[i] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         if (w_wtake) begin
            r_k0 <= g0;
            r_s1 <= SW'(g0) + SW'(g1) + SW'(g2);
            r_s2 <= SW'(g0) - SW'(g1) + SW'(g2);
            r_k3 <= g2;
         end
         // stage p0: tile transform
         if (w_accept) begin
            r_cnt     <= 2'd0;
            r_m_p0[0] <= MW'(d0) - MW'(d2);
            r_m_p0[1] <= MW'(d1) + MW'(d2);
            r_m_p0[2] <= MW'(d2) - MW'(d1);
            r_m_p0[3] <= MW'(d1) - MW'(d3);
         end
         // stage p1: shared-multiplier passes
         if (r_state == S_MUL) begin
            r_cnt <= r_cnt + 2'd1;
            for (int j = 0; j < NUM_MUL; j++) r_t_p1[w_idx[j]] <= w_prod[j];
         end
         // stage p2: output transform
         if (r_state == S_SUM) begin
            r_y0_p2 <= f_narrow(w_y0);
            r_y1_p2 <= f_narrow(w_y1);
         end
      end
   end

endmodule

// File: tb/tb_winograd_f23_engine.sv
module tb_winograd_f23_engine;

   localparam int DW = 16;
   localparam int OW = 2*DW+2;

   logic clk = 1'b0;
   logic rst_n;
   logic w_load, in_valid, out_ready;
   logic signed [DW-1:0] g0, g1, g2, d0, d1, d2, d3;
   logic wr [3], ir [3], ov [3], bz [3];
   logic signed [OW-1:0] y0 [3], y1 [3];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   winograd_f23_engine #(.DATA_W(DW), .NUM_MUL(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_ready(wr[0]),
      .g0(g0), .g1(g1), .g2(g2), .in_valid(in_valid), .in_ready(ir[0]),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3), .out_valid(ov[0]),
      .out_ready(out_ready), .y0(y0[0]), .y1(y1[0]), .busy(bz[0]));
   winograd_f23_engine #(.DATA_W(DW), .NUM_MUL(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_ready(wr[1]),
      .g0(g0), .g1(g1), .g2(g2), .in_valid(in_valid), .in_ready(ir[1]),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3), .out_valid(ov[1]),
      .out_ready(out_ready), .y0(y0[1]), .y1(y1[1]), .busy(bz[1]));
   winograd_f23_engine #(.DATA_W(DW), .NUM_MUL(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_ready(wr[2]),
      .g0(g0), .g1(g1), .g2(g2), .in_valid(in_valid), .in_ready(ir[2]),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3), .out_valid(ov[2]),
      .out_ready(out_ready), .y0(y0[2]), .y1(y1[2]), .busy(bz[2]));

   function automatic int passes(input int k);
      return (k == 0) ? 4 : (k == 1) ? 2 : 1;
   endfunction

   // Direct convolution, the definition the engine must reproduce.
   function automatic longint ref_y0(input longint a0, a1, a2, b0, b1, b2, b3);
      return b0*a0 + b1*a1 + b2*a2;
   endfunction
   function automatic longint ref_y1(input longint a0, a1, a2, b0, b1, b2, b3);
      return b1*a0 + b2*a1 + b3*a2;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Model state per instance
   longint fg [3][3];
   logic   exp_valid [3];
   longint exp_y0 [3], exp_y1 [3];
   int     acc_cyc [3];
   int     cyc = 0;
   logic   ov_prev [3];
   longint last_y0 [3], last_y1 [3];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 3; t++) fg[k][t] <= 0;
            exp_valid[k] <= 1'b0;
         end
      end else begin
         cyc <= cyc + 1;
         for (int k = 0; k < 3; k++) begin
            if (ov[k] && out_ready) exp_valid[k] <= 1'b0;
            if (w_load && wr[k]) begin
               fg[k][0] <= longint'(g0);
               fg[k][1] <= longint'(g1);
               fg[k][2] <= longint'(g2);
            end
            if (in_valid && ir[k]) begin
               exp_y0[k]    <= ref_y0(fg[k][0], fg[k][1], fg[k][2],
                                      longint'(d0), longint'(d1), longint'(d2), longint'(d3));
               exp_y1[k]    <= ref_y1(fg[k][0], fg[k][1], fg[k][2],
                                      longint'(d0), longint'(d1), longint'(d2), longint'(d3));
               exp_valid[k] <= 1'b1;
               acc_cyc[k]   <= cyc + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst_n && ov[k]) begin
            if (!exp_valid[k]) chk($sformatf("spurious_out[%0d]", k), 1, 0);
            else begin
               chk($sformatf("y0[%0d]", k), longint'(y0[k]), exp_y0[k]);
               chk($sformatf("y1[%0d]", k), longint'(y1[k]), exp_y1[k]);
            end
            if (!ov_prev[k])
               chk($sformatf("latency[%0d]", k), longint'(cyc - acc_cyc[k]), longint'(passes(k) + 1));
            if (out_ready) begin
               last_y0[k] <= longint'(y0[k]);
               last_y1[k] <= longint'(y1[k]);
            end
         end
         ov_prev[k] <= rst_n & ov[k];
      end
   end

   task automatic load(input int a0, input int a1, input int a2);
      g0 = 16'(a0); g1 = 16'(a1); g2 = 16'(a2);
      w_load = 1'b1;
      @(negedge clk);
      w_load = 1'b0;
   endtask

   task automatic tile(input int b0, input int b1, input int b2, input int b3);
      d0 = 16'(b0); d1 = 16'(b1); d2 = 16'(b2); d3 = 16'(b3);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((bz[0] || bz[1] || bz[2]) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk("wait_idle_timeout", 1, 0);
      @(negedge clk);
   endtask

   task automatic lit(input string nm, input longint e0, input longint e1);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s_y0[%0d]", nm, k), last_y0[k], e0);
         chk($sformatf("%s_y1[%0d]", nm, k), last_y1[k], e1);
      end
   endtask

   longint hold0 [3], hold1 [3];

   initial begin
      rst_n = 1'b0; w_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      g0 = '0; g1 = '0; g2 = '0; d0 = '0; d1 = '0; d2 = '0; d3 = '0;
      for (int k = 0; k < 3; k++) begin
         last_y0[k] = -1; last_y1[k] = -1; ov_prev[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_out_valid[%0d]", k), longint'(ov[k]), 0);
         chk($sformatf("rst_y0[%0d]", k), longint'(y0[k]), 0);
         chk($sformatf("rst_y1[%0d]", k), longint'(y1[k]), 0);
         chk($sformatf("rst_w_ready[%0d]", k), longint'(wr[k]), 1);
         chk($sformatf("rst_in_ready[%0d]", k), longint'(ir[k]), 1);
         chk($sformatf("rst_busy[%0d]", k), longint'(bz[k]), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      chk("ref_a_y0", ref_y0(1, 1, 1, 1, 2, 3, 4), 6);
      chk("ref_a_y1", ref_y1(1, 1, 1, 1, 2, 3, 4), 9);
      chk("ref_b_y1", ref_y1(1, 0, 0, 5, 7, -3, 2), 7);
      chk("ref_c_y0", ref_y0(-32768, -32768, -32768, -32768, -32768, -32768, -32768), 64'sd3221225472);

      load(1, 1, 1);
      tile(1, 2, 3, 4);
      wait_idle();
      lit("basic", 6, 9);

      load(1, 0, 0);
      tile(5, 7, -3, 2);
      wait_idle();
      lit("odd_half", 5, 7);

      load(-32768, -32768, -32768);
      tile(-32768, -32768, -32768, -32768);
      wait_idle();
      lit("ext_a", 64'sd3221225472, 64'sd3221225472);

      load(-32768, 32767, -32768);
      tile(32767, -32768, 32767, -32768);
      wait_idle();
      lit("ext_b", -64'sd3221127168, 64'sd3221159937);

      // Backpressure with a competing tile offered throughout.
      out_ready = 1'b0;
      tile(1, 2, 3, 4);
      repeat (6) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         hold0[k] = longint'(y0[k]);
         hold1[k] = longint'(y1[k]);
      end
      d0 = 16'sd9; d1 = 16'sd9; d2 = 16'sd9; d3 = 16'sd9;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_in_ready[%0d]", k), longint'(ir[k]), 0);
            chk($sformatf("bp_out_valid[%0d]", k), longint'(ov[k]), 1);
            chk($sformatf("bp_y0_stable[%0d]", k), longint'(y0[k]), hold0[k]);
            chk($sformatf("bp_y1_stable[%0d]", k), longint'(y1[k]), hold1[k]);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bp_release_ov[%0d]", k), longint'(ov[k]), 0);
         chk($sformatf("bp_release_ir[%0d]", k), longint'(ir[k]), 1);
         chk($sformatf("bp_no_second[%0d]", k), longint'(bz[k]), 0);
      end

      // Load and tile together: load wins, tile follows with new filter.
      g0 = 16'sd2; g1 = 16'sd3; g2 = 16'sd4;
      d0 = 16'sd1; d1 = 16'sd1; d2 = 16'sd1; d3 = 16'sd1;
      w_load = 1'b1; in_valid = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("both_in_ready[%0d]", k), longint'(ir[k]), 0);
         chk($sformatf("both_w_ready[%0d]", k), longint'(wr[k]), 1);
      end
      @(negedge clk);
      w_load = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      g0 = 16'sd100; g1 = 16'sd100; g2 = 16'sd100;
      w_load = 1'b1;
      #1;
      for (int k = 0; k < 3; k++)
         chk($sformatf("mul_w_ready[%0d]", k), longint'(wr[k]), 0);
      @(negedge clk);
      w_load = 1'b0;
      wait_idle();
      lit("deferred", 9, 9);
      tile(1, 0, 0, 0);
      wait_idle();
      lit("load_ignored", 2, 0);

      // Reset while multiplying.
      tile(1, 2, 3, 4);
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("mrst_ov[%0d]", k), longint'(ov[k]), 0);
         chk($sformatf("mrst_y0[%0d]", k), longint'(y0[k]), 0);
         chk($sformatf("mrst_busy[%0d]", k), longint'(bz[k]), 0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mrst_after_ov", longint'(ov[1]), 0);
         chk("mrst_after_y1", longint'(y1[1]), 0);
      end
      tile(1, 2, 3, 4);
      wait_idle();
      lit("no_filter", 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/winograd_f23_engine.md
# winograd_f23_engine

Parametrised Winograd F(2,3) convolution engine: for each accepted 4-sample input tile d0..d3 it produces two outputs y0 = d0·g0 + d1·g1 + d2·g2 and y1 = d1·g0 + d2·g1 + d3·g2 against a stored 3-tap filter. It is the successor to the fixed 16-bit single-multiplier Winograd multiplier and adds:
- generic data width;
- 1/2/4 shared multipliers;
- a persistent filter register;
- valid/ready streaming on input and output;
- exact arithmetic, with no truncation of the half-sum filter terms.

It sits between the tile buffer and the accumulation stage of the convolution datapath.

## Interface
- DATA_W, 16, signed width of d* and g* samples (4..32)
- NUM_MUL, 1, parallel multipliers: 1, 2 or 4; products per pass
- OUT_W, 2*DATA_W+2, output width (derived, not overridden)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- w_load  in  1  filter load strobe; taken only when w_ready=1
- w_ready  out  1  high in IDLE
- g0, g1, g2  in  DATA_W  signed filter taps, sampled on an accepted w_load
- in_valid  in  1  tile valid
- in_ready  out  1  high in IDLE when w_load=0
- d0, d1, d2, d3  in  DATA_W  signed tile samples, sampled on in_valid & in_ready
- out_valid  out  1  result valid; held until it is consumed
- out_ready  in  1  downstream accept
- y0, y1  out  OUT_W  signed results, stable while out_valid=1
- busy  out  1  high in any state other than IDLE

## Operation
**Filter load** (w_load & w_ready), registered from g:
- k0 = g0
- s1 = g0 + g1 + g2
- s2 = g0 − g1 + g2
- k3 = g2

s1 and s2 are DATA_W+2 bits and are not halved. The filter persists until the next load or reset; reset clears all filter registers to 0.

**Tile accept** (in_valid & in_ready), registered, each DATA_W+1 bits signed:
- m0 = d0 − d2
- m1 = d1 + d2
- m2 = d2 − d1
- m3 = d1 − d3

**Products:**
- t0 = m0·k0
- t1 = m1·s1
- t2 = m2·s2
- t3 = m3·k3

Each product is 2·DATA_W+3 bits signed. They are computed in P = 4/NUM_MUL passes, with NUM_MUL products per pass in index order, and each product is registered.

**Sum:**
- h = (t1 + t2) >>> 1 and g = (t1 − t2) >>> 1.
- Both t1+t2 and t1−t2 are always even, so the shift is exact.
- y0 = t0 + h
- y1 = g − t3
- Computed at full width, then narrowed to OUT_W. This is lossless for all inputs.

**FSM:**
- IDLE: in_valid & in_ready → MUL, pass counter = 0.
- MUL: compute pass; counter increments; on the last pass (counter = P−1) → SUM.
- SUM: register y0/y1, set out_valid → HOLD.
- HOLD: on out_ready → clear out_valid → IDLE.

**Priority and error rules:**
- w_load and in_valid both high in IDLE: the load wins and in_ready is forced low that cycle. The tile is accepted on a later cycle using the new filter.
- w_load outside IDLE is ignored; the filter is unchanged.
- A tile processed with no filter ever loaded yields y0 = y1 = 0.

## Timing
- Reset values: state IDLE, out_valid 0, y0/y1 0, w_ready 1, in_ready 1, busy 0. All internal registers are 0.
- Latency: with the tile accepted at edge E0, out_valid rises at edge E(P+1).
  - NUM_MUL=1: 5 cycles.
  - NUM_MUL=2: 3 cycles.
  - NUM_MUL=4: 2 cycles.
- A filter loaded at edge E applies to any tile accepted at E+1 or later.
- One tile in flight at a time. in_ready is low from E0 until the cycle after out_valid & out_ready.
- Minimum tile spacing is P+3 cycles when out_ready=1.
- Backpressure: y0/y1 and out_valid are held indefinitely while out_ready=0.
- rst_n asserted in any state: immediate return to reset values. The in-flight tile is discarded, the filter is cleared, and there is no partial output.

## Test plan
- NUM_MUL=1: load g=(1,1,1), then tile d=(1,2,3,4) → y0=6, y1=9; out_valid high exactly 5 cycles after accept.
- Odd half-sum check: g=(1,0,0), d=(5,7,−3,2) → y0=5, y1=7 (s1=s2=1 must not truncate).
- Extremes, DATA_W=16, NUM_MUL=4: g all −32768, d all −32768 → y0=y1=3221225472. Then g=(−32768,32767,−32768), d=(32767,−32768,32767,−32768) → exact 34-bit results matching the reference model. Latency 2.
- Backpressure: hold out_ready=0 for 10 cycles → y stable, in_ready=0, second tile not accepted. Raise out_ready → handshake, then in_ready=1 the next cycle.
- Simultaneous w_load and in_valid in IDLE: the load is taken and the tile is deferred one cycle. The result uses the new filter. w_load during MUL is ignored.
- Reset during MUL, NUM_MUL=2: out_valid stays 0 and y=0. A tile after release with no reload → y0=y1=0.
